// File: rtl/booth_mult_seq_pkg.sv
// Shared miniSRC definitions for the sequential Booth multiplier:
// datapath width, FSM state encoding and Booth step decode.
package booth_mult_seq_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_t;

    function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
        case ({q0, qm1})
            2'b01:   return BOOTH_ADD;
            2'b10:   return BOOTH_SUB;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_mult_seq_cla_add_sub.sv
// Combinational carry-lookahead add/subtract: sum = a + (inv_b ? ~b : b) + cin.
// Carries come from a parallel-prefix (Kogge-Stone) generate/propagate tree.
module cla_add_sub #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         inv_b,
    input  logic         cin,
    output logic [N-1:0] sum
);

    localparam int LV = $clog2(N);

    logic [N-1:0] bx;
    logic [N-1:0] pb;
    logic [N-1:0] gc;
    logic [N-1:0] pc;
    logic [N-1:0] gn;
    logic [N-1:0] pn;

    // Position 0 carries cin; position j holds bit j-1, so the prefix
    // at position i is exactly the carry into bit i.
    always_comb begin
        bx = inv_b ? ~b : b;
        pb = a ^ bx;
        gc = '0;
        pc = '0;
        gn = '0;
        pn = '0;
        gc[0] = cin;
        for (int j = 1; j < N; j++) begin
            gc[j] = a[j-1] & bx[j-1];
            pc[j] = pb[j-1];
        end
        for (int l = 0; l < LV; l++) begin
            gn = gc;
            pn = pc;
            for (int i = (1 << l); i < N; i++) begin
                gn[i] = gc[i] | (pc[i] & gc[i-(1<<l)]);
                pn[i] = pc[i] & pc[i-(1<<l)];
            end
            gc = gn;
            pc = pn;
        end
        sum = pb ^ gc;
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth signed multiplier with start/busy/done handshake.
// One Booth step per cycle through the CLA add/sub; product lands in hi/lo.
import booth_mult_seq_pkg::*;

module booth_mult_seq #(
    parameter int WIDTH = DATA_W,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    booth_op_t          op;
    logic               sub;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     step_a;

    assign op  = booth_decode(q_q[0], qm1_q);
    assign sub = (op == BOOTH_SUB);

    // A is one bit wider than M so that subtracting the most negative M
    // cannot overflow the accumulator.
    cla_add_sub #(
        .N(WIDTH + 1)
    ) u_add (
        .a     (a_q),
        .b     ({m_q[WIDTH-1], m_q}),
        .inv_b (sub),
        .cin   (sub),
        .sum   (sum)
    );

    assign step_a = (op == BOOTH_NOP) ? a_q : sum;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = multiplicand;
                    q_d     = multiplier;
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = {step_a[WIDTH], step_a[WIDTH:1]};
                q_d   = {step_a[0], q_q[WIDTH-1:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                hi_d    = a_q[WIDTH-1:0];
                lo_d    = q_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: vector table, handshake corner
// cases and random signed pairs against a sign-extended reference multiply.
module tb_booth_mult_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    booth_mult_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] m;
        logic [31:0] q;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [63:0] prod;
        int          acc;
    } exp_t;

    exp_t sb[$];
    vec_t vt[8];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] m,
                                            input logic [31:0] q);
        logic [63:0] me;
        logic [63:0] qe;
        me = {{32{m[31]}}, m};
        qe = {{32{q[31]}}, q};
        return me * qe;
    endfunction

    // Scoreboard: every done pulse pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_done: got done=1 at cycle %0d expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    check("product", {hi, lo}, e.prod);
                    check("latency", 64'(cyc - e.acc), 64'd33);
                end
            end
        end
    end

    task automatic launch(input logic [31:0] m, input logic [31:0] q);
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        sb.push_back('{ref_mul(m, q), cyc + 1});
        @(negedge clk);
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    task automatic wait_done(input int c0);
        int n;
        n = 0;
        while (done_cnt == c0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == c0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
        end
    endtask

    task automatic run_op(input logic [31:0] m, input logic [31:0] q);
        int c0;
        c0 = done_cnt;
        launch(m, q);
        wait_done(c0);
    endtask

    initial begin
        int          c0;
        int          n;
        int          acc;
        logic [31:0] ph;
        logic [31:0] pl;
        logic        unstable;
        logic [31:0] rm;
        logic [31:0] rq;

        vt[0] = '{32'h00000005, 32'h00000003, 32'h00000000, 32'h0000000F};
        vt[1] = '{32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6};
        vt[2] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vt[3] = '{32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
        vt[4] = '{32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
        vt[5] = '{32'h00000001, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        vt[6] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001};
        vt[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("reset_outputs", {30'd0, busy, done, hi, lo}, 64'd0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        check("idle_outputs", {30'd0, busy, done, hi, lo}, 64'd0);

        // Table vectors, with the constant products cross-checked too.
        foreach (vt[i]) begin
            check("table_const", ref_mul(vt[i].m, vt[i].q), {vt[i].hi, vt[i].lo});
            run_op(vt[i].m, vt[i].q);
            check("table_hilo", {hi, lo}, {vt[i].hi, vt[i].lo});
        end

        // start held high while busy, operands churning every cycle.
        c0 = done_cnt;
        @(negedge clk);
        multiplicand = 32'h7FFFFFFF;
        multiplier   = 32'h80000000;
        start        = 1'b1;
        sb.push_back('{64'hC0000000_80000000, cyc + 1});
        n = 0;
        while (n < 80) begin
            @(negedge clk);
            n++;
            if (done_cnt != c0) break;
            multiplicand = $urandom;
            multiplier   = $urandom;
        end
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("single_done", 64'(done_cnt - c0), 64'd1);

        // Reset in the middle of RUN aborts with no done pulse.
        c0 = done_cnt;
        @(negedge clk);
        multiplicand = 32'h00001234;
        multiplier   = 32'h00005678;
        start        = 1'b1;
        acc          = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < acc + 10) @(negedge clk);
        check("busy_mid_run", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_outputs", {31'd0, busy, hi, lo}, 64'd0);
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - c0), 64'd0);
        run_op(32'd2, 32'd2);
        check("after_abort", {hi, lo}, 64'd4);

        // Back-to-back: previous result must hold until the new done.
        run_op(32'h00000005, 32'hFFFFFFFD);
        ph = hi;
        pl = lo;
        c0 = done_cnt;
        launch(32'hFFFFFFFF, 32'hFFFFFFFF);
        unstable = 1'b0;
        n = 0;
        while (done_cnt == c0 && n < 80) begin
            if (hi !== ph || lo !== pl) unstable = 1'b1;
            @(negedge clk);
            n++;
        end
        check("hilo_stable", {63'd0, unstable}, 64'd0);
        check("b2b_result", {hi, lo}, 64'd1);

        // Random signed pairs, with occasional extreme operands.
        for (int k = 0; k < 200; k++) begin
            rm = $urandom;
            rq = $urandom;
            if (k % 16 == 0) rm = 32'h80000000;
            if (k % 16 == 1) rq = 32'h7FFFFFFF;
            run_op(rm, rq);
        end

        repeat (5) @(negedge clk);
        check("drain", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
